// File: rtl/input_pkg.sv
// Shared types and constants for the button input chain: repeat FSM states,
// channel indices and default timing values.
package input_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DELAY  = 2'd1,
      REPEAT = 2'd2
   } rpt_state_e;

   localparam int CH_ROT   = 0;
   localparam int CH_LEFT  = 1;
   localparam int CH_RIGHT = 2;

   localparam int DEBOUNCE_5MS_50MHZ = 250000;
   localparam int DAS_DEFAULT        = 17;
   localparam int ARR_DEFAULT        = 5;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/input_channel.sv
// One button slice: 2-FF sync, debouncer, rise detect, DAS/ARR repeat FSM,
// pending latch and tick-gated registered action pulse.
module input_channel
   import input_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_5MS_50MHZ,
   parameter int DAS_TICKS       = DAS_DEFAULT,
   parameter int ARR_TICKS       = ARR_DEFAULT,
   parameter bit REPEAT_EN       = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic tick,
   input  logic btn_in,
   output logic act_out,
   output logic held
);

   localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
   localparam int TK_W = $clog2(max2(DAS_TICKS, ARR_TICKS) + 1);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [TK_W-1:0] DAS_L   = TK_W'(DAS_TICKS);
   localparam logic [TK_W-1:0] ARR_L   = TK_W'(ARR_TICKS);

   logic            sync1_q, sync1_d, sync2_q, sync2_d;
   logic [DB_W-1:0] db_cnt_q, db_cnt_d;
   logic            held_q, held_d, held_prev_q, held_prev_d;
   rpt_state_e      state_q, state_d;
   logic [TK_W-1:0] tk_cnt_q, tk_cnt_d, tk_next;
   logic            pending_q, pending_d, act_q, act_d;
   logic            rise, rpt_set;

   always_comb begin
      sync1_d     = btn_in;
      sync2_d     = sync1_q;
      db_cnt_d    = '0;
      held_d      = held_q;
      held_prev_d = held_q;
      state_d     = state_q;
      tk_cnt_d    = tk_cnt_q;
      tk_next     = tk_cnt_q + TK_W'(1);
      rpt_set     = 1'b0;
      rise        = held_q & ~held_prev_q;

      if (sync2_q != held_q) begin
         if (db_cnt_q == DB_LAST) held_d = sync2_q;
         else                     db_cnt_d = db_cnt_q + DB_W'(1);
      end

      // Release wins over any tick arriving in the same cycle.
      if (!held_q) begin
         state_d  = IDLE;
         tk_cnt_d = '0;
      end else begin
         case (state_q)
            IDLE: if (rise && REPEAT_EN) begin
               state_d  = DELAY;
               tk_cnt_d = '0;
            end
            DELAY: if (tick) begin
               if (tk_next == DAS_L) begin
                  rpt_set  = 1'b1;
                  state_d  = REPEAT;
                  tk_cnt_d = '0;
               end else tk_cnt_d = tk_next;
            end
            REPEAT: if (tick) begin
               if (tk_next == ARR_L) begin
                  rpt_set  = 1'b1;
                  tk_cnt_d = '0;
               end else tk_cnt_d = tk_next;
            end
            default: begin
               state_d  = IDLE;
               tk_cnt_d = '0;
            end
         endcase
      end

      // A press edge is consumed by a coincident tick; repeat requests wait for the next one.
      act_d     = tick & (pending_q | rise);
      pending_d = ((pending_q | rise) & ~tick) | rpt_set;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         db_cnt_q    <= '0;
         held_q      <= 1'b0;
         held_prev_q <= 1'b0;
         state_q     <= IDLE;
         tk_cnt_q    <= '0;
         pending_q   <= 1'b0;
         act_q       <= 1'b0;
      end else begin
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         db_cnt_q    <= db_cnt_d;
         held_q      <= held_d;
         held_prev_q <= held_prev_d;
         state_q     <= state_d;
         tk_cnt_q    <= tk_cnt_d;
         pending_q   <= pending_d;
         act_q       <= act_d;
      end
   end

   assign act_out = act_q;
   assign held    = held_q;

endmodule

// File: rtl/input_repeat_ctrl.sv
// N-channel button front end: polarity fix, then one input_channel per key
// producing frame-gated action pulses with optional auto-repeat.
module input_repeat_ctrl
   import input_pkg::*;
#(
   parameter int              N_CH            = 3,
   parameter bit              ACTIVE_LOW      = 1'b1,
   parameter int              DEBOUNCE_CYCLES = DEBOUNCE_5MS_50MHZ,
   parameter int              DAS_TICKS       = DAS_DEFAULT,
   parameter int              ARR_TICKS       = ARR_DEFAULT,
   parameter logic [N_CH-1:0] REPEAT_MASK     = 3'b110
) (
   input  logic            CLOCK_50,
   input  logic            resetn,
   input  logic            tick_input,
   input  logic [N_CH-1:0] btn_raw,
   output logic [N_CH-1:0] act_out,
   output logic [N_CH-1:0] held
);

   if (DAS_TICKS < 1 || ARR_TICKS < 1 || DEBOUNCE_CYCLES < 2) begin : g_param_err
      $error("input_repeat_ctrl: need DAS_TICKS>=1, ARR_TICKS>=1, DEBOUNCE_CYCLES>=2");
   end

   logic [N_CH-1:0] btn_fix;
   assign btn_fix = btn_raw ^ {N_CH{ACTIVE_LOW}};

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      input_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .DAS_TICKS       (DAS_TICKS),
         .ARR_TICKS       (ARR_TICKS),
         .REPEAT_EN       (REPEAT_MASK[i])
      ) u_ch (
         .clk     (CLOCK_50),
         .rst     (resetn),
         .tick    (tick_input),
         .btn_in  (btn_fix[i]),
         .act_out (act_out[i]),
         .held    (held[i])
      );
   end

endmodule

// File: tb/tb_input_repeat_ctrl.sv
// Directed bench for input_repeat_ctrl with a per-cycle reference model and
// hand-computed checks on pulse timing for each scenario.
module tb_input_repeat_ctrl;
   localparam int DB = 4, DAS = 3, ARR = 2;

   logic       clk = 1'b0, resetn = 1'b1, tick_input = 1'b0;
   logic [2:0] btn_raw = 3'b111;
   logic [2:0] act_out, held;
   logic [2:0] rmask = 3'b110;

   input_repeat_ctrl #(
      .N_CH(3), .ACTIVE_LOW(1'b1), .DEBOUNCE_CYCLES(DB),
      .DAS_TICKS(DAS), .ARR_TICKS(ARR), .REPEAT_MASK(3'b110)
   ) dut (
      .CLOCK_50(clk), .resetn(resetn), .tick_input(tick_input),
      .btn_raw(btn_raw), .act_out(act_out), .held(held)
   );

   always #5 clk = ~clk;

   int n_cmp = 0, n_err = 0;
   int cyc = 0, tdiv = 0, tick_no = 0, last_tick_cyc = -100;
   bit cmp_en = 1'b0;

   // Frame strobe: one cycle in ten.
   always @(posedge clk) begin
      cyc++;
      #1;
      tdiv       = (tdiv == 9) ? 0 : tdiv + 1;
      tick_input = (tdiv == 9);
      if (tick_input) begin
         tick_no++;
         last_tick_cyc = cyc;
      end
   end

   // Reference model: held flips after DB consecutive opposite samples; the
   // repeat schedule is "n ticks since press: n==DAS or DAS+k*ARR".
   logic [2:0]    m_s1 = '0, m_s2 = '0, m_held = '0, m_prev = '0;
   logic [2:0]    m_pend = '0, m_act = '0, m_active = '0;
   logic [DB-1:0] m_hist [3];
   int            m_nt [3];

   always @(posedge clk) begin : model
      logic rise, setr;
      logic [2:0] fix;
      fix = ~btn_raw;
      if (resetn) begin
         m_s1 = '0; m_s2 = '0; m_held = '0; m_prev = '0;
         m_pend = '0; m_act = '0; m_active = '0;
         for (int i = 0; i < 3; i++) begin m_hist[i] = '0; m_nt[i] = 0; end
      end else begin
         for (int i = 0; i < 3; i++) begin
            rise = m_held[i] & ~m_prev[i];
            setr = 1'b0;
            if (!m_held[i]) begin
               m_active[i] = 1'b0; m_nt[i] = 0;
            end else if (m_active[i]) begin
               if (tick_input) begin
                  m_nt[i]++;
                  if (m_nt[i] == DAS || (m_nt[i] > DAS && (m_nt[i] - DAS) % ARR == 0)) setr = 1'b1;
               end
            end else if (rise) begin
               m_active[i] = rmask[i]; m_nt[i] = 0;
            end
            m_act[i]  = tick_input & (m_pend[i] | rise);
            m_pend[i] = ((m_pend[i] | rise) & ~tick_input) | setr;
            m_prev[i] = m_held[i];
            m_hist[i] = {m_hist[i][DB-2:0], m_s2[i]};
            if (m_hist[i] == {DB{~m_held[i]}}) m_held[i] = ~m_held[i];
            m_s2[i] = m_s1[i];
            m_s1[i] = fix[i];
         end
      end
   end

   always @(negedge clk) if (cmp_en) begin
      n_cmp++;
      if (act_out !== m_act) begin
         n_err++;
         $display("FAIL act_out cyc=%0d got=%b expected=%b", cyc, act_out, m_act);
      end
      n_cmp++;
      if (held !== m_held) begin
         n_err++;
         $display("FAIL held cyc=%0d got=%b expected=%b", cyc, held, m_held);
      end
   end

   // Pulse log: tick number consumed, and distance from that tick's cycle.
   int p0[$], p1[$], p2[$], d0[$], d1[$];
   always @(negedge clk) begin
      if (act_out[0]) begin p0.push_back(tick_no); d0.push_back(cyc - last_tick_cyc); end
      if (act_out[1]) begin p1.push_back(tick_no); d1.push_back(cyc - last_tick_cyc); end
      if (act_out[2]) p2.push_back(tick_no);
   end

   task automatic chk(input string nm, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin @(posedge clk); #2; end
   endtask

   task automatic align(input int v);
      for (int k = 0; k < 12; k++) begin
         if (tdiv == v) return;
         step(1);
      end
   endtask

   task automatic wait_tick(input int t);
      for (int k = 0; k < 2000 && tick_no < t; k++) step(1);
   endtask

   task automatic clr();
      p0.delete(); p1.delete(); p2.delete(); d0.delete(); d1.delete();
   endtask

   int base, edge_cyc, rise_cyc, rst_cyc;

   initial begin
      resetn = 1'b1;
      step(3);
      resetn = 1'b0;
      cmp_en = 1'b1;
      chk("reset act_out", int'(act_out), 0);
      chk("reset held", int'(held), 0);
      step(5);

      // Bounce on left
      clr(); align(0);
      for (int k = 0; k < 10; k++) begin btn_raw[1] = (k % 2 == 0) ? 1'b0 : 1'b1; step(2); end
      btn_raw[1] = 1'b0;
      edge_cyc = cyc;
      rise_cyc = -1;
      for (int k = 0; k < 20 && rise_cyc < 0; k++) begin step(1); if (held[1]) rise_cyc = cyc; end
      chk("bounce held delay", rise_cyc - edge_cyc, 6);
      step(12 - (cyc - edge_cyc));
      btn_raw[1] = 1'b1;
      step(30);
      chk("bounce pulse count", p1.size(), 1);
      if (p1.size() > 0) chk("bounce pulse after tick", d1[0], 1);

      // Tap on rotate
      clr(); align(0);
      btn_raw[0] = 1'b0; step(8); btn_raw[0] = 1'b1;
      step(50);
      chk("tap pulse count", p0.size(), 1);
      if (p0.size() > 0) chk("tap pulse after tick", d0[0], 1);

      // Hold left for 100 ticks
      clr(); align(0); base = tick_no;
      btn_raw[1] = 1'b0;
      wait_tick(base + 100); step(2);
      btn_raw[1] = 1'b1;
      step(20);
      chk("hold pulse count", p1.size(), 50);
      if (p1.size() == 50) begin
         chk("hold press tick", p1[0] - base, 1);
         chk("hold DAS tick", p1[1] - base, 4);
         chk("hold first ARR tick", p1[2] - base, 6);
         chk("hold second ARR tick", p1[3] - base, 8);
         chk("hold last tick", p1[49] - base, 100);
      end

      // Release mid-DELAY, then re-press
      clr(); align(0); base = tick_no;
      btn_raw[1] = 1'b0; wait_tick(base + 2); btn_raw[1] = 1'b1;
      step(40);
      chk("mid-delay pulse count", p1.size(), 1);
      clr(); align(0); base = tick_no;
      btn_raw[1] = 1'b0; wait_tick(base + 4); btn_raw[1] = 1'b1;
      step(30);
      chk("repress pulse count", p1.size(), 2);
      if (p1.size() == 2) chk("repress DAS tick", p1[1] - base, 4);

      // Edge pulse coincident with tick
      clr(); align(3); base = tick_no;
      btn_raw[1] = 1'b0; wait_tick(base + 2); btn_raw[1] = 1'b1;
      step(30);
      chk("collision pulse count", p1.size(), 1);
      if (p1.size() > 0) begin
         chk("collision tick", p1[0] - base, 1);
         chk("collision next cycle", d1[0], 1);
      end

      // Left+right together, reset during REPEAT
      clr(); align(0); base = tick_no;
      btn_raw[2:1] = 2'b00;
      wait_tick(base + 5); step(1);
      chk("mixed left pulses", p1.size(), 2);
      chk("mixed right pulses", p2.size(), 2);
      if (p2.size() == 2) chk("mixed right DAS tick", p2[1] - base, 4);
      clr();
      resetn = 1'b1; rst_cyc = cyc; step(1); resetn = 1'b0;
      chk("post-reset act_out", int'(act_out), 0);
      chk("post-reset held", int'(held), 0);
      rise_cyc = -1;
      for (int k = 0; k < 20 && rise_cyc < 0; k++) begin step(1); if (held[1] && held[2]) rise_cyc = cyc; end
      chk("re-debounce delay", rise_cyc - (rst_cyc + 1), 6);
      step(5);
      btn_raw[2:1] = 2'b11;
      step(30);
      chk("post-reset left pulses", p1.size(), 1);
      chk("post-reset right pulses", p2.size(), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
